// File: rtl/systolic_skew_feeder.sv
// Left-edge feeder for the PE systolic array: buffers one ROWS x DEPTH tile of
// activations, then replays it with row r delayed by r cycles and zero fill outside the tile.
module systolic_skew_feeder #(
    parameter int ROWS       = 4,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ROWS*DATA_WIDTH-1:0] in_vec,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ROWS*DATA_WIDTH-1:0] out_a,
    output logic                       out_valid,
    output logic                       done
);

    localparam int LCW    = $clog2(DEPTH + 1);
    localparam int TW     = $clog2(DEPTH + ROWS);
    localparam int LAST_T = DEPTH + ROWS - 2;

    typedef enum logic [1:0] {
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                      state;
    logic [LCW-1:0]              load_cnt;
    logic [TW-1:0]               t;
    logic [DATA_WIDTH-1:0]       buffer   [ROWS][DEPTH];
    logic [DATA_WIDTH-1:0]       buf_next [ROWS][DEPTH];
    logic                        hs;
    logic                        last_load;
    logic [TW-1:0]               t_next;
    logic [ROWS*DATA_WIDTH-1:0]  skew_next;

    assign hs        = (state == S_LOAD) && in_valid && in_ready;
    assign last_load = hs && (load_cnt == LCW'(DEPTH - 1));
    assign t_next    = (state == S_STREAM) ? t + 1'b1 : '0;

    // The first stream beat is computed on the edge that writes the last column,
    // so the skew is taken from the buffer contents including this cycle's write.
    always_comb begin
        buf_next  = buffer;
        skew_next = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int d = 0; d < DEPTH; d++) begin
                if (hs && (int'(load_cnt) == d)) begin
                    buf_next[r][d] = in_vec[r*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int d = 0; d < DEPTH; d++) begin
                if (int'(t_next) == r + d) begin
                    skew_next[r*DATA_WIDTH +: DATA_WIDTH] = buf_next[r][d];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    buffer[r][d] <= '0;
                end
            end
        end else if (hs) begin
            buffer <= buf_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            load_cnt  <= '0;
            t         <= '0;
            out_a     <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    in_ready <= 1'b1;
                    if (hs) begin
                        load_cnt <= load_cnt + 1'b1;
                        if (last_load) begin
                            state     <= S_STREAM;
                            t         <= '0;
                            out_a     <= skew_next;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                S_STREAM: begin
                    if (t == TW'(LAST_T)) begin
                        state     <= S_DONE;
                        out_a     <= '0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        t     <= t_next;
                        out_a <= skew_next;
                    end
                end
                S_DONE: begin
                    state    <= S_LOAD;
                    done     <= 1'b0;
                    load_cnt <= '0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the PE systolic array.
- Buffers one activation tile of ROWS x DEPTH signed elements. The tile arrives as DEPTH column vectors over a valid/ready handshake.
- Replays the tile into the array's left edge with the diagonal skew the array needs: row r is delayed r cycles. Positions outside the tile are zero-filled.
- PEs only accumulate and have no enable, so zero fill adds nothing to their sums. The feeder streams without stalls.

Parameters:
- ROWS, 4, number of array rows; one left-edge input per row.
- DEPTH, 4, reduction length K; number of column vectors per tile.
- DATA_WIDTH, 8, signed element width; matches PE DATA_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_vec  in  ROWS*DATA_WIDTH  column vector k; element r at bits [r*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  1  in_vec valid.
- in_ready  out  1  feeder can accept a vector; high only in LOAD.
- out_a  out  ROWS*DATA_WIDTH  skewed row data to the array left edge; row r at bits [r*DATA_WIDTH +: DATA_WIDTH]; registered.
- out_valid  out  1  high during every STREAM cycle.
- done  out  1  one-cycle pulse after the last STREAM cycle.

Behaviour:
- Reset (async, immediate):
  - state=LOAD, load count=0, stream count t=0.
  - buffer cleared to 0.
  - out_a=0, out_valid=0, done=0.
  - in_ready rises to 1 after reset deasserts.
- Reset mid-LOAD or mid-STREAM aborts the tile. Partial data is discarded and the next accepted vector is k=0.

State machine: LOAD -> STREAM -> DONE -> LOAD.

- LOAD:
  - in_ready=1. A handshake (in_valid & in_ready) on an edge writes in_vec into buffer column k=load count, then increments the count.
  - On the DEPTH-th handshake edge:
    - state->STREAM, t->0.
    - out_a loads the t=0 values; out_valid->1.
    - in_ready drops in the same edge.
  - No handshake: state and buffer hold; in_valid may stay low indefinitely.
- STREAM (exactly DEPTH+ROWS-1 cycles, t=0..DEPTH+ROWS-2):
  - Registered out_a for stream cycle t holds, per row r: buffer[r][t-r] if 0 <= t-r < DEPTH, else 0.
  - Each edge computes values for t+1.
  - in_ready=0; in_vec and in_valid are ignored.
  - No stall or backpressure: the array has no enable.
- Leaving STREAM: at the edge ending t=DEPTH+ROWS-2, state->DONE, out_a->0, out_valid->0, done->1.
- DONE:
  - Lasts one cycle; done=1, out_a=0, in_ready=0.
  - Next edge: state->LOAD, done->0, load count=0, in_ready->1.
- Latency: the first nonzero row-0 element appears the cycle after the final load handshake. Row r's first element appears r cycles later.
- Throughput: one tile per DEPTH (min) + DEPTH+ROWS-1 + 1 cycles; no overlap of load and stream.
- Arithmetic: pure data movement, no widening. Values pass bit-exact, including the most negative value (-128 at DATA_WIDTH=8).
- Counters: load count width clog2(DEPTH+1); t width clog2(DEPTH+ROWS). No wrap-around is reachable.

Test Plan:
- Basic skew (ROWS=2, DEPTH=3):
  - Stimulus: load (row0,row1) = (1,2), (3,4), (5,6) back-to-back.
  - Required response: 4 STREAM cycles with out_a rows (1,0), (3,2), (5,4), (0,6); then done=1 with out_a=(0,0); then in_ready=1.
- Gapped input:
  - Stimulus: same vectors with in_valid low 3 cycles between each.
  - Required response: identical stream. Stream starts exactly one cycle after the third handshake.
- Signed extremes (DATA_WIDTH=8):
  - Stimulus: load (-128,127), (-1,0), (0,-128).
  - Required response: rows (-128,0), (-1,127), (0,0), (0,-128), bit-exact.
- Input ignored while busy:
  - Stimulus: hold in_valid=1 with changing data throughout STREAM and DONE.
  - Required response: in_ready=0 throughout and the stream is unaffected. The next tile accepts only after done.
- Reset mid-operation:
  - Stimulus: assert rst at stream cycle t=1, release, then load (7,8), (9,10), (11,12).
  - Required response: outputs 0 immediately on rst. The new stream is (7,0), (9,8), (11,10), (0,12), with no stale data.
- Integration:
  - Stimulus: drive a 2x2 PE array. The feeder streams A=[[1,3,5],[2,4,6]]; a matched top-edge feeder streams B = 3x2 identity-padded.
  - Required response: PE accumulators equal A x B once the stream plus ROWS+columns drain cycles have elapsed.
